gpo_route_matrix: RTL and testbench



---
 rtl/gpo_route_pkg.sv | 22 ++
 rtl/gpo_sync_edge.sv | 60 ++++++
 rtl/gpo_route_matrix.sv | 168 ++++++++++++++++
 tb/tb_gpo_route_matrix.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpo_route_pkg.sv
// gpo_route_pkg
// Shared types and helpers for the GPO route matrix.
//   gpo_mode_t  : per-output drive mode (pass, invert, force-0, force-1)
//   RESET_MODE  : mode of every table entry after reset (source index resets to 0)
//   sel_width() : index width for n items, never less than 1 bit
package gpo_route_pkg;

  typedef enum logic [1:0] {
    GPO_PASS = 2'd0,
    GPO_INV  = 2'd1,
    GPO_ZERO = 2'd2,
    GPO_ONE  = 2'd3
  } gpo_mode_t;

  // Reset entry is {src 0, force-0}, so an unconfigured pin is a quiet low.
  localparam gpo_mode_t RESET_MODE = GPO_ZERO;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gpo_sync_edge.sv
// gpo_sync_edge
// Multi-stage synchroniser with an optional rising-edge detector.
// Parameters:
//   STAGES  : synchroniser depth
//   WIDTH   : number of independent bits synchronised
//   EDGE_EN : 1 builds the rising-edge detector, 0 ties rise_o low
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   async_i       : asynchronous inputs
//   sync_o        : synchronised level (last synchroniser stage)
//   rise_o        : one-cycle pulse per rising edge of sync_o
module gpo_sync_edge #(
  parameter int STAGES  = 2,
  parameter int WIDTH   = 1,
  parameter bit EDGE_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= async_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign sync_o = stage_q[STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic [WIDTH-1:0] prev_q;
      logic [STAGES:0]  fill_q;

      // fill_q blanks edge detection until the chain and prev_q hold real
      // samples, so a strobe already high at reset release never fires.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          prev_q <= '0;
          fill_q <= '0;
        end else begin
          prev_q <= sync_o;
          fill_q <= {fill_q[STAGES-1:0], 1'b1};
        end
      end

      assign rise_o = sync_o & ~prev_q & {WIDTH{fill_q[STAGES]}};
    end else begin : g_no_edge
      assign rise_o = '0;
    end
  endgenerate

endmodule

// File: rtl/gpo_route_matrix.sv
// gpo_route_matrix
// Routes any of NUM_IN asynchronous RFIC GPO lines to any of NUM_OUT
// accessory pins with a per-pin mode. Software writes entries into a shadow
// table with the cfg_clk_pin strobe and copies the whole shadow into the
// active table with the cfg_commit_pin strobe, so outputs never see a
// partially written map.
// Optional feature macro: GPO_ROUTE_READBACK_EN adds cfg_rdata, a registered
// readback of shadow[cfg_out_sel] (0 when cfg_out_sel is out of range).
// Ports:
//   sys_clk, rstn   : clock, asynchronous active-low reset
//   cfg_clk_pin     : async write strobe (rising edge writes shadow)
//   cfg_commit_pin  : async commit strobe (rising edge copies shadow->active)
//   cfg_in_sel      : source line index for a write (quasi-static)
//   cfg_out_sel     : destination pin index for a write (quasi-static)
//   cfg_mode        : mode for a write: 0 pass, 1 invert, 2 force-0, 3 force-1
//   input_lines     : async RFIC GPO lines
//   output_lines    : routed pins, registered
//   cfg_err         : sticky out-of-range write flag, cleared by commit
//   commit_cnt      : wrapping commit counter
//   cfg_rdata       : (GPO_ROUTE_READBACK_EN only) {src, mode} readback
module gpo_route_matrix
  import gpo_route_pkg::*;
#(
  parameter int NUM_IN      = 8,
  parameter int NUM_OUT     = 10,
  parameter int SYNC_STAGES = 2,
  localparam int SEL_W      = sel_width(NUM_IN),
  localparam int OSEL_W     = sel_width(NUM_OUT)
) (
  input  logic               sys_clk,
  input  logic               rstn,
  input  logic               cfg_clk_pin,
  input  logic               cfg_commit_pin,
  input  logic [SEL_W-1:0]   cfg_in_sel,
  input  logic [OSEL_W-1:0]  cfg_out_sel,
  input  logic [1:0]         cfg_mode,
  input  logic [NUM_IN-1:0]  input_lines,
  output logic [NUM_OUT-1:0] output_lines,
  output logic               cfg_err,
  output logic [7:0]         commit_cnt
`ifdef GPO_ROUTE_READBACK_EN
  ,
  output logic [SEL_W+1:0]   cfg_rdata
`endif
);

  logic [NUM_IN-1:0] sync_in;
  logic [NUM_IN-1:0] in_rise_unused;
  logic              wr_rise, cm_rise;
  logic              wr_level_unused, cm_level_unused;

  gpo_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(NUM_IN), .EDGE_EN(1'b0)) u_sync_in (
    .clk_i(sys_clk), .rst_ni(rstn), .async_i(input_lines),
    .sync_o(sync_in), .rise_o(in_rise_unused)
  );

  gpo_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(1), .EDGE_EN(1'b1)) u_sync_wr (
    .clk_i(sys_clk), .rst_ni(rstn), .async_i(cfg_clk_pin),
    .sync_o(wr_level_unused), .rise_o(wr_rise)
  );

  gpo_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(1), .EDGE_EN(1'b1)) u_sync_cm (
    .clk_i(sys_clk), .rst_ni(rstn), .async_i(cfg_commit_pin),
    .sync_o(cm_level_unused), .rise_o(cm_rise)
  );

  logic [SEL_W-1:0]   shadow_src_q  [NUM_OUT];
  logic [SEL_W-1:0]   shadow_src_d  [NUM_OUT];
  gpo_mode_t          shadow_mode_q [NUM_OUT];
  gpo_mode_t          shadow_mode_d [NUM_OUT];
  logic [SEL_W-1:0]   active_src_q  [NUM_OUT];
  logic [SEL_W-1:0]   active_src_d  [NUM_OUT];
  gpo_mode_t          active_mode_q [NUM_OUT];
  gpo_mode_t          active_mode_d [NUM_OUT];
  logic [NUM_OUT-1:0] out_q, out_d;
  logic               err_q, err_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               wr_ok;

  // cfg_* buses are quasi-static, so they are sampled directly at strobe detect.
  assign wr_ok = (int'(cfg_out_sel) < NUM_OUT) && (int'(cfg_in_sel) < NUM_IN);

  always_comb begin
    shadow_src_d  = shadow_src_q;
    shadow_mode_d = shadow_mode_q;
    active_src_d  = active_src_q;
    active_mode_d = active_mode_q;
    err_d         = err_q;
    cnt_d         = cnt_q;
    out_d         = '0;

    if (wr_rise) begin
      if (wr_ok) begin
        for (int j = 0; j < NUM_OUT; j++) begin
          if (int'(cfg_out_sel) == j) begin
            shadow_src_d[j]  = cfg_in_sel;
            shadow_mode_d[j] = gpo_mode_t'(cfg_mode);
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end

    // Commit copies the post-write shadow, so a same-cycle write is included.
    if (cm_rise) begin
      active_src_d  = shadow_src_d;
      active_mode_d = shadow_mode_d;
      cnt_d         = cnt_q + 8'd1;
      err_d         = 1'b0;
    end

    for (int j = 0; j < NUM_OUT; j++) begin
      case (active_mode_q[j])
        GPO_PASS: out_d[j] =  sync_in[active_src_q[j]];
        GPO_INV:  out_d[j] = ~sync_in[active_src_q[j]];
        GPO_ZERO: out_d[j] = 1'b0;
        GPO_ONE:  out_d[j] = 1'b1;
        default:  out_d[j] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j < NUM_OUT; j++) begin
        shadow_src_q[j]  <= '0;
        shadow_mode_q[j] <= RESET_MODE;
        active_src_q[j]  <= '0;
        active_mode_q[j] <= RESET_MODE;
      end
      out_q <= '0;
      err_q <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      shadow_src_q  <= shadow_src_d;
      shadow_mode_q <= shadow_mode_d;
      active_src_q  <= active_src_d;
      active_mode_q <= active_mode_d;
      out_q         <= out_d;
      err_q         <= err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign output_lines = out_q;
  assign cfg_err      = err_q;
  assign commit_cnt   = cnt_q;

`ifdef GPO_ROUTE_READBACK_EN
  logic [SEL_W+1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      if (int'(cfg_out_sel) == j) rdata_d = {shadow_src_q[j], shadow_mode_q[j]};
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign cfg_rdata = rdata_q;
`endif

endmodule

// File: tb/tb_gpo_route_matrix.sv
module tb_gpo_route_matrix;
  import gpo_route_pkg::*;

  localparam int NUM_IN      = 8;
  localparam int NUM_OUT     = 10;
  localparam int SYNC_STAGES = 2;
  localparam int SEL_W       = 3;
  localparam int OSEL_W      = 4;

  // ---------------- clock / reset / DUT ----------------
  logic               sys_clk        = 1'b0;
  logic               rstn           = 1'b0;
  logic               cfg_clk_pin    = 1'b0;
  logic               cfg_commit_pin = 1'b0;
  logic [SEL_W-1:0]   cfg_in_sel     = '0;
  logic [OSEL_W-1:0]  cfg_out_sel    = '0;
  logic [1:0]         cfg_mode       = '0;
  logic [NUM_IN-1:0]  input_lines    = '0;
  logic [NUM_OUT-1:0] output_lines;
  logic               cfg_err;
  logic [7:0]         commit_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 sys_clk = ~sys_clk;

  gpo_route_matrix #(
    .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .sys_clk(sys_clk), .rstn(rstn),
    .cfg_clk_pin(cfg_clk_pin), .cfg_commit_pin(cfg_commit_pin),
    .cfg_in_sel(cfg_in_sel), .cfg_out_sel(cfg_out_sel), .cfg_mode(cfg_mode),
    .input_lines(input_lines), .output_lines(output_lines),
    .cfg_err(cfg_err), .commit_cnt(commit_cnt)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Tables hold plain ints: src index and mode number.
  int sh_src [NUM_OUT];
  int sh_mode[NUM_OUT];
  int ac_src [NUM_OUT];
  int ac_mode[NUM_OUT];
  int m_err, m_cnt;

  function automatic void model_reset();
    for (int j = 0; j < NUM_OUT; j++) begin
      sh_src[j] = 0; sh_mode[j] = 2; ac_src[j] = 0; ac_mode[j] = 2;
    end
    m_err = 0; m_cnt = 0;
  endfunction

  function automatic void model_write(input int o, input int i, input int m);
    if (o < NUM_OUT && i < NUM_IN) begin
      sh_src[o] = i; sh_mode[o] = m;
    end else begin
      m_err = 1;
    end
  endfunction

  function automatic void model_commit();
    for (int j = 0; j < NUM_OUT; j++) begin
      ac_src[j] = sh_src[j]; ac_mode[j] = sh_mode[j];
    end
    m_cnt = (m_cnt + 1) % 256;
    m_err = 0;
  endfunction

  function automatic logic [NUM_OUT-1:0] model_out(input logic [NUM_IN-1:0] lines);
    logic [NUM_OUT-1:0] r;
    r = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      case (ac_mode[j])
        0: r[j] = lines[ac_src[j]];
        1: r[j] = ~lines[ac_src[j]];
        2: r[j] = 1'b0;
        default: r[j] = 1'b1;
      endcase
    end
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    tick(3);
    rstn = 1'b1;
    tick(SYNC_STAGES + 4);
  endtask

  task automatic set_bus(input int o, input int i, input int m);
    cfg_out_sel = OSEL_W'(o);
    cfg_in_sel  = SEL_W'(i);
    cfg_mode    = 2'(m);
    tick(4);
  endtask

  task automatic pulse(input logic wr, input logic cm);
    cfg_clk_pin    = wr;
    cfg_commit_pin = cm;
    tick(SYNC_STAGES + 3);
    cfg_clk_pin    = 1'b0;
    cfg_commit_pin = 1'b0;
    tick(SYNC_STAGES + 3);
  endtask

  // ---------------- vector table ----------------
  // op: 0 none, 1 write {o, i, m}, 2 commit. Expected values after settling.
  typedef struct {
    int         op;
    int         o;
    int         i;
    int         m;
    logic [7:0] lines;
    logic [9:0] exp_out;
    logic       exp_err;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1,  3, 5, 0, 8'h20, 10'h000, 1'b0, 8'd0}; // written, not committed
    vecs[1] = '{2,  0, 0, 0, 8'h20, 10'h008, 1'b0, 8'd1}; // out3 follows in5
    vecs[2] = '{1,  0, 2, 1, 8'h04, 10'h000, 1'b0, 8'd1};
    vecs[3] = '{1,  9, 0, 3, 8'h04, 10'h000, 1'b0, 8'd1};
    vecs[4] = '{2,  0, 0, 0, 8'h04, 10'h200, 1'b0, 8'd2}; // out0=~in2=0, out9=1
    vecs[5] = '{0,  0, 0, 0, 8'h00, 10'h201, 1'b0, 8'd2}; // out0=1
    vecs[6] = '{1, 12, 1, 3, 8'h00, 10'h201, 1'b1, 8'd2}; // out of range
    vecs[7] = '{2,  0, 0, 0, 8'h00, 10'h201, 1'b0, 8'd3}; // shadow unchanged, err cleared
    vecs[8] = '{0,  0, 0, 0, 8'h24, 10'h208, 1'b0, 8'd3};

    // reset with all inputs high
    input_lines = 8'hFF;
    reset_dut();
    check("reset_out", 32'(output_lines), 32'h0);
    check("reset_err", 32'(cfg_err), 32'h0);
    check("reset_cnt", 32'(commit_cnt), 32'h0);

    for (int v = 0; v < 9; v++) begin
      input_lines = vecs[v].lines;
      if (vecs[v].op == 1) begin
        set_bus(vecs[v].o, vecs[v].i, vecs[v].m);
        pulse(1'b1, 1'b0);
      end else if (vecs[v].op == 2) begin
        pulse(1'b0, 1'b1);
      end
      tick(SYNC_STAGES + 2);
      check($sformatf("vec%0d_out", v), 32'(output_lines), 32'(vecs[v].exp_out));
      check($sformatf("vec%0d_err", v), 32'(cfg_err), 32'(vecs[v].exp_err));
      check($sformatf("vec%0d_cnt", v), 32'(commit_cnt), 32'(vecs[v].exp_cnt));
    end

    // data path latency: in5 falls, out3 follows after SYNC_STAGES+1 edges
    input_lines = 8'h04;
    tick(SYNC_STAGES);
    check("lat_data_hold", 32'(output_lines), 32'h208);
    tick(1);
    check("lat_data", 32'(output_lines), 32'h200);

    // commit latency: table and counter at S+1 edges, pins at S+2
    set_bus(1, 1, 3);
    pulse(1'b1, 1'b0);
    check("pending_write_not_live", 32'(output_lines), 32'h200);
    cfg_commit_pin = 1'b1;
    tick(SYNC_STAGES + 1);
    check("lat_commit_cnt", 32'(commit_cnt), 32'd4);
    check("lat_commit_hold", 32'(output_lines), 32'h200);
    tick(1);
    check("lat_commit_out", 32'(output_lines), 32'h202);
    cfg_commit_pin = 1'b0;
    tick(SYNC_STAGES + 3);

    // write and commit strobes together: new entry is included
    set_bus(2, 0, 3);
    pulse(1'b1, 1'b1);
    tick(SYNC_STAGES + 2);
    check("same_cycle_out", 32'(output_lines), 32'h206);
    check("same_cycle_cnt", 32'(commit_cnt), 32'd5);

    // reset in the middle of a commit with a non-default map
    input_lines = 8'hFF;
    set_bus(4, 0, 3);
    pulse(1'b1, 1'b0);
    cfg_commit_pin = 1'b1;
    tick(SYNC_STAGES);
    #2 rstn = 1'b0;
    #1;
    check("rst_async_out", 32'(output_lines), 32'h0);
    check("rst_async_err", 32'(cfg_err), 32'h0);
    check("rst_async_cnt", 32'(commit_cnt), 32'h0);
    tick(2);
    rstn = 1'b1;                 // commit strobe still high at release
    tick(10);
    check("rst_strobe_high_cnt", 32'(commit_cnt), 32'h0);
    check("rst_strobe_high_out", 32'(output_lines), 32'h0);
    cfg_commit_pin = 1'b0;
    tick(SYNC_STAGES + 3);
    pulse(1'b0, 1'b1);
    tick(SYNC_STAGES + 2);
    check("rst_tables_cnt", 32'(commit_cnt), 32'd1);
    check("rst_tables_out", 32'(output_lines), 32'h0);

    // randomized operations against the model
    reset_dut();
    model_reset();
    for (int k = 0; k < 150; k++) begin
      int r, o, i, m;
      r = int'($urandom_range(0, 9));
      o = int'($urandom_range(0, 15));
      i = int'($urandom_range(0, 7));
      m = int'($urandom_range(0, 3));
      if (r < 6) begin
        set_bus(o, i, m);
        pulse(1'b1, 1'b0);
        model_write(o, i, m);
      end else if (r < 9) begin
        pulse(1'b0, 1'b1);
        model_commit();
      end else begin
        set_bus(o, i, m);
        pulse(1'b1, 1'b1);
        model_write(o, i, m);
        model_commit();
      end
      input_lines = NUM_IN'($urandom);
      tick(SYNC_STAGES + 2);
      check($sformatf("rand%0d_out", k), 32'(output_lines), 32'(model_out(input_lines)));
      check($sformatf("rand%0d_err", k), 32'(cfg_err), 32'(m_err));
      check($sformatf("rand%0d_cnt", k), 32'(commit_cnt), 32'(m_cnt));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
